// File: rtl/fetch_pkg.sv
// Shared types and sizes for the byte-wide instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED,
        S_ERROR
    } state_t;

    localparam int BYTES_PER_INSTR = 4;
    localparam int BYTE_IDX_W      = 2;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Per-byte wait counter; flags the wait cycle that would hit the limit.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    // An acking cycle never counts as a wait, so the limit ack is accepted.
    assign expired = (TIMEOUT != 0) && enable && (count == CW'(LAST));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetches four bytes per instruction over req/ack and issues a cpu_step.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_ADDR_W = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic                  run,
    input  logic                  step,
    output logic                  mem_req,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [31:0]           instruction,
    output logic                  cpu_step,
    output logic                  halted,
    output logic                  fetch_error
);

    state_t                           state;
    logic [BYTE_IDX_W-1:0]            byte_idx;
    logic [BYTES_PER_INSTR-1:0][7:0]  shadow;
    logic [BYTES_PER_INSTR-1:0][7:0]  word_nxt;
    logic                             single;
    logic                             last_byte;
    logic                             in_fetch;
    logic                             expired;
    logic                             unused_pc;

    assign in_fetch  = (state == S_FETCH);
    assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_INSTR - 1));
    assign unused_pc = ^pc[31:MEM_ADDR_W];

    // Gated by mem_req so an abandoned request also zeroes the address.
    assign mem_addr = mem_req ? pc[MEM_ADDR_W-1:0] + MEM_ADDR_W'(byte_idx)
                              : '0;

    always_comb begin
        word_nxt           = shadow;
        word_nxt[byte_idx] = mem_rdata;
    end

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_fetch || mem_ack),
        .enable  (in_fetch && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            byte_idx    <= '0;
            shadow      <= '0;
            instruction <= '0;
            cpu_step    <= 1'b0;
            halted      <= 1'b0;
            fetch_error <= 1'b0;
            single      <= 1'b0;
        end else begin
            cpu_step <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                    end else begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        shadow   <= word_nxt;
                        byte_idx <= byte_idx + BYTE_IDX_W'(1);
                        if (last_byte) begin
                            state       <= S_ISSUE;
                            mem_req     <= 1'b0;
                            cpu_step    <= 1'b1;
                            instruction <= word_nxt;
                        end
                    end else if (expired) begin
                        state       <= S_ERROR;
                        mem_req     <= 1'b0;
                        fetch_error <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    single <= 1'b0;
                    if (run && !single) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                    end else begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (run || step) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                        halted  <= 1'b0;
                        single  <= !run;
                    end
                end
                S_ERROR: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl with a variable-latency byte memory.
module tb_imem_fetch_ctrl;

    localparam int AW = 10;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   pc = '0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_rdata = '0;
    logic [31:0]   instruction;
    logic          cpu_step;
    logic          halted;
    logic          fetch_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    int delay_byte = -1;
    int delay_n = 0;
    bit never_ack = 1'b0;
    int wcnt = 0;
    bit prev_ack = 1'b0;

    logic [7:0]  mem [0:(1<<AW)-1];
    logic [31:0] exp_q[$];
    int          step_cyc[$];
    int          ack_log[$];
    int          req_log[$];

    imem_fetch_ctrl #(
        .MEM_ADDR_W (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .run         (run),
        .step        (step),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .cpu_step    (cpu_step),
        .halted      (halted),
        .fetch_error (fetch_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // CPU model: PC advances only on the cpu_step edge.
    always @(posedge clk) if (reset && cpu_step) pc <= pc + 32'd4;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [AW-1:0] b0, b1, b2, b3;
        b0 = a[AW-1:0];
        b1 = b0 + 10'd1;
        b2 = b0 + 10'd2;
        b3 = b0 + 10'd3;
        return {mem[b3], mem[b2], mem[b1], mem[b0]};
    endfunction

    // Memory responder and scoreboard consumer.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!mem_req) begin
            mem_ack = 1'b0;
            wcnt = 0;
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) wcnt = 0;
            mem_ack = !never_ack &&
                      (int'(mem_addr[1:0]) != delay_byte || wcnt >= delay_n);
            mem_rdata = mem[mem_addr];
            if (!mem_ack) wcnt++;
            prev_ack = mem_ack;
            req_log.push_back(int'(mem_addr));
            if (mem_ack) ack_log.push_back(int'(mem_addr));
        end
        if (cpu_step) begin
            step_cyc.push_back(cyc - base + 1);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_extra got=%h want=none", instruction);
            end else begin
                e = exp_q.pop_front();
                if (instruction !== e) begin
                    failures++;
                    $display("FAIL scoreboard_word got=%h want=%h", instruction, e);
                end
            end
        end
    end

    task automatic apply_reset(input logic [31:0] start_pc, input logic run_v);
        @(negedge clk);
        reset = 1'b0;
        run = run_v;
        step = 1'b0;
        never_ack = 1'b0;
        delay_byte = -1;
        delay_n = 0;
        pc = start_pc;
        exp_q.delete();
        step_cyc.delete();
        ack_log.delete();
        req_log.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base = cyc;
    endtask

    task automatic wait_steps(input int n, input int budget, output bit ok);
        int k = 0;
        while (step_cyc.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (step_cyc.size() >= n);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0;
        run = 1'b1;
        pc = 32'h123;
        #1;
        checks += 6;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        if (instruction !== '0) begin failures++; $display("FAIL reset_instr got=%h want=0", instruction); end
        if (cpu_step !== 1'b0) begin failures++; $display("FAIL reset_cpu_step got=%b want=0", cpu_step); end
        if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", halted); end
        if (fetch_error !== 1'b0) begin failures++; $display("FAIL reset_fetch_error got=%b want=0", fetch_error); end
    endtask

    task automatic test_zero_wait;
        bit ok;
        mem[0] = 8'h04; mem[1] = 8'h03; mem[2] = 8'h02; mem[3] = 8'h01;
        apply_reset(32'h0, 1'b1);
        exp_q.push_back(32'h01020304);
        exp_q.push_back(word_at(32'h4));
        exp_q.push_back(word_at(32'h8));
        wait_steps(3, 40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zw_steps got=%0d want=3", step_cyc.size()); end
        run = 1'b0;
        @(negedge clk);
        #1;
        checks += 2;
        if (halted !== 1'b1) begin failures++; $display("FAIL zw_halted got=%b want=1", halted); end
        if (mem_req !== 1'b0) begin failures++; $display("FAIL zw_req_off got=%b want=0", mem_req); end
        for (int i = 0; i < 3 && i < step_cyc.size(); i++) begin
            checks++;
            if (step_cyc[i] != 6 + 5 * i) begin
                failures++;
                $display("FAIL zw_step_cycle[%0d] got=%0d want=%0d", i, step_cyc[i], 6 + 5 * i);
            end
        end
    endtask

    task automatic test_wait_states;
        bit ok;
        int held = 0;
        apply_reset(32'h40, 1'b1);
        delay_byte = 2;
        delay_n = 3;
        for (int i = 0; i < 3; i++) exp_q.push_back(word_at(32'h40 + 4 * i));
        wait_steps(3, 60, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ws_steps got=%0d want=3", step_cyc.size()); end
        run = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 'h42) held++;
        checks += 2;
        if (held != 4) begin failures++; $display("FAIL ws_addr_hold got=%0d want=4", held); end
        // Three waits with TIMEOUT=4 puts the ack on the limit cycle.
        if (fetch_error !== 1'b0) begin failures++; $display("FAIL ws_limit_ack got=%b want=0", fetch_error); end
        for (int i = 0; i < 3 && i < step_cyc.size(); i++) begin
            checks++;
            if (step_cyc[i] != 9 + 8 * i) begin
                failures++;
                $display("FAIL ws_step_cycle[%0d] got=%0d want=%0d", i, step_cyc[i], 9 + 8 * i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_halt_step;
        bit ok;
        int k = 0;
        apply_reset(32'h80, 1'b1);
        exp_q.push_back(word_at(32'h80));
        while (!(mem_req && mem_addr == 10'h81) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (k >= 20) begin failures++; $display("FAIL hs_reach_byte1 got=timeout want=addr_81"); end
        run = 1'b0;
        wait_steps(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL hs_inflight_issue got=%0d want=1", step_cyc.size()); end
        @(negedge clk);
        #1;
        checks += 2;
        if (halted !== 1'b1) begin failures++; $display("FAIL hs_halted got=%b want=1", halted); end
        if (mem_req !== 1'b0) begin failures++; $display("FAIL hs_req_off got=%b want=0", mem_req); end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (step_cyc.size() != 1) begin failures++; $display("FAIL hs_stay_halted got=%0d want=1", step_cyc.size()); end
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back(word_at(32'h84 + 4 * s));
            step = 1'b1;
            @(negedge clk);
            #1;
            step = 1'b0;
            wait_steps(2 + s, 20, ok);
            @(negedge clk);
            #1;
            checks += 2;
            if (!ok) begin failures++; $display("FAIL hs_single_step[%0d] got=%0d want=%0d", s, step_cyc.size(), 2 + s); end
            if (halted !== 1'b1 || mem_req !== 1'b0) begin
                failures++;
                $display("FAIL hs_rehalt[%0d] got=%b%b want=10", s, halted, mem_req);
            end
        end
        repeat (6) @(negedge clk);
        #1;
        checks += 2;
        if (step_cyc.size() != 3) begin failures++; $display("FAIL hs_step_count got=%0d want=3", step_cyc.size()); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL hs_queue_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        int k = 0;
        apply_reset(32'h100, 1'b1);
        never_ack = 1'b1;
        while (!fetch_error && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks += 3;
        if (fetch_error !== 1'b1) begin failures++; $display("FAIL to_flag got=%b want=1", fetch_error); end
        if (req_log.size() != TO) begin failures++; $display("FAIL to_req_cycles got=%0d want=%0d", req_log.size(), TO); end
        if (mem_req !== 1'b0) begin failures++; $display("FAIL to_req_off got=%b want=0", mem_req); end
        repeat (10) @(negedge clk);
        #1;
        checks += 2;
        if (step_cyc.size() != 0) begin failures++; $display("FAIL to_no_step got=%0d want=0", step_cyc.size()); end
        if (fetch_error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b want=1", fetch_error); end
        reset = 1'b0;
        #1;
        checks++;
        if (fetch_error !== 1'b0) begin failures++; $display("FAIL to_reset_clear got=%b want=0", fetch_error); end
    endtask

    task automatic test_wrap;
        bit ok;
        int want[4] = '{'h3FE, 'h3FF, 'h000, 'h001};
        apply_reset(32'h3FE, 1'b1);
        exp_q.push_back(word_at(32'h3FE));
        wait_steps(1, 20, ok);
        run = 1'b0;
        checks += 2;
        if (!ok) begin failures++; $display("FAIL wr_step got=%0d want=1", step_cyc.size()); end
        if (ack_log.size() != 4) begin failures++; $display("FAIL wr_ack_count got=%0d want=4", ack_log.size()); end
        for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
            checks++;
            if (ack_log[i] != want[i]) begin
                failures++;
                $display("FAIL wr_addr[%0d] got=%h want=%h", i, ack_log[i], want[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch;
        bit ok;
        int k = 0;
        mem[32'h20] = 8'hA5;
        apply_reset(32'h20, 1'b1);
        exp_q.push_back(word_at(32'h20));
        wait_steps(1, 20, ok);
        while (!(mem_req && mem_addr == 10'h26) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        checks++;
        if (!ok || k >= 20) begin failures++; $display("FAIL rm_reach got=steps%0d want=in_second_fetch", step_cyc.size()); end
        #2;
        reset = 1'b0;
        #1;
        checks += 4;
        if (mem_req !== 1'b0) begin failures++; $display("FAIL rm_req got=%b want=0", mem_req); end
        if (mem_addr !== '0) begin failures++; $display("FAIL rm_addr got=%h want=0", mem_addr); end
        if (instruction !== '0) begin failures++; $display("FAIL rm_instr got=%h want=0", instruction); end
        if (cpu_step !== 1'b0) begin failures++; $display("FAIL rm_cpu_step got=%b want=0", cpu_step); end
        @(negedge clk);
        ack_log.delete();
        exp_q.push_back(word_at(32'h24));
        reset = 1'b1;
        base = cyc;
        wait_steps(2, 20, ok);
        run = 1'b0;
        checks += 2;
        if (!ok || step_cyc[1] != 6) begin
            failures++;
            $display("FAIL rm_restart_cycle got=%0d want=6", ok ? step_cyc[1] : -1);
        end
        if (ack_log.size() == 0 || ack_log[0] != 'h24) begin
            failures++;
            $display("FAIL rm_restart_addr got=%h want=024", ack_log.size() ? ack_log[0] : -1);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_halt_step();
        test_timeout();
        test_wrap();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
